// File: rtl/periph_timer_pkg.sv
// Shared definitions for the countdown timer peripheral: state type, control/status
// field positions and the bus addresses used by the decoder and software headers.
package periph_timer_pkg;

    typedef enum logic {T_IDLE, T_RUN} timer_state_t;

    localparam int unsigned CTRL_PERIODIC_BIT = 31;
    localparam int unsigned ST_DONE_BIT       = 0;
    localparam int unsigned ST_BUSY_BIT       = 1;
    localparam int unsigned ST_MISSED_BIT     = 2;

    localparam logic [31:0] TIMER_CTRL_ADDR = 32'h18;
    localparam logic [31:0] TIMER_DONE_ADDR = 32'h1C;

endpackage

// File: rtl/periph_timer_if.sv
// Decoder-side bus for the timer: control write strobe/data, status word and irq.
interface periph_timer_if;

    logic        ctrl_we;
    logic [31:0] ctrl_wdata;
    logic [31:0] done_rdata;
    logic        irq;

    modport master (
        output ctrl_we,
        output ctrl_wdata,
        input  done_rdata,
        input  irq
    );

    modport slave (
        input  ctrl_we,
        input  ctrl_wdata,
        output done_rdata,
        output irq
    );

endinterface

// File: rtl/periph_timer_tick_gen.sv
// Prescaler: free-runs 0..PRESCALE-1 while enabled and flags the last cycle of each tick.
module tick_gen #(
    parameter int unsigned PRESCALE = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    // Held at zero when idle so a fresh run always gets a full first tick.
    always_ff @(posedge clk) begin
        if (reset || clr || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped countdown timer: one-shot or auto-reload, sticky done/missed status
// and a single-cycle irq on every expiry. Acknowledge/stop is a write with N = 0.
module periph_timer
    import periph_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 100,
    parameter int unsigned CNT_W    = 24
) (
    input  logic           clk,
    input  logic           reset,
    periph_timer_if.slave  bus
);

    timer_state_t     state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] n_field;
    logic             periodic;
    logic             done_q;
    logic             missed_q;
    logic             irq_q;
    logic             tick;
    logic             run;
    logic [31:0]      status;
    logic [30-CNT_W:0] unused_ctrl;

    assign n_field     = bus.ctrl_wdata[CNT_W-1:0];
    assign unused_ctrl = bus.ctrl_wdata[30:CNT_W];
    assign run         = (state == T_RUN);

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .clr   (bus.ctrl_we),
        .tick  (tick)
    );

    // A write always takes priority over an expiry landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= T_IDLE;
            count    <= '0;
            reload   <= '0;
            periodic <= 1'b0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            if (bus.ctrl_we) begin
                done_q   <= 1'b0;
                missed_q <= 1'b0;
                if (n_field != '0) begin
                    state    <= T_RUN;
                    count    <= n_field;
                    reload   <= n_field;
                    periodic <= bus.ctrl_wdata[CTRL_PERIODIC_BIT];
                end else begin
                    state <= T_IDLE;
                    count <= '0;
                end
            end else if (run && tick) begin
                if (count == CNT_W'(1)) begin
                    done_q   <= 1'b1;
                    missed_q <= missed_q | done_q;
                    irq_q    <= 1'b1;
                    if (periodic) begin
                        count <= reload;
                    end else begin
                        state <= T_IDLE;
                        count <= '0;
                    end
                end else begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        status                = '0;
        status[ST_DONE_BIT]   = done_q;
        status[ST_BUSY_BIT]   = run;
        status[ST_MISSED_BIT] = missed_q;
    end

    assign bus.done_rdata = status;
    assign bus.irq        = irq_q;

endmodule
